xor_nina_acc: RTL

Parametrised, registered masked XOR/accumulator for the NINA case study. It operates on SHARES Boolean shares, each carrying BITS data bits encoded with a (K+1)-fold repetition code. Every share is processed only with the same-index share of the other operand, and every codeword copy only with the same copy, so the non-interference and non-accumulation properties hold. It adds a valid/ready pipeline stage, a multi-beat accumulate mode, and a per-share repetition-code fault check with a sticky alarm. It sits between masked NINA gadgets wherever a linear layer must be registered or folded over several beats.

---
 rtl/xor_nina_acc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/xor_nina_acc.sv
// xor_nina_acc -- registered masked XOR / accumulator stage for NINA gadgets.
//
// Operands carry SHARES Boolean shares. Each share is a (K+1)-fold repetition
// codeword of BITS data bits. Share i, copy r occupies
// [i*W + r*BITS +: BITS], where W = BITS*(K+1).
// Each share, copy and bit is combined only with the same share, copy and bit
// of the other operand.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake
//   in_op                 0 = pass (c = a^b), 1 = accumulate
//   in_last               closes an accumulate sequence
//   port_a, port_b        SHARES*W operands
//   port_c / out_valid    registered result and its valid flag
//   out_ready             downstream consume
//   fault                 sticky repetition-code alarm; locks the block until rst

// Per-share slice: XOR combine with optional accumulator feedback, and the
// copy-consistency check of this share only.
module xor_nina_share #(
    parameter  int BITS = 1,
    parameter  int K    = 2,
    localparam int W    = BITS * (K + 1)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] acc,
    input  logic         sel_acc,
    output logic [W-1:0] sum,
    output logic         flt
);
    assign sum = sel_acc ? (acc ^ a ^ b) : (a ^ b);

    // Every copy must equal copy 0, for a and for b independently.
    always_comb begin
        flt = 1'b0;
        for (int r = 1; r <= K; r++) begin
            if (a[r*BITS +: BITS] != a[0 +: BITS]) flt = 1'b1;
            if (b[r*BITS +: BITS] != b[0 +: BITS]) flt = 1'b1;
        end
    end
endmodule

module xor_nina_acc #(
    parameter  int SHARES = 3,
    parameter  int BITS   = 1,
    parameter  int K      = 2,
    localparam int W      = BITS * (K + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_op,
    input  logic                in_last,
    input  logic [SHARES*W-1:0] port_a,
    input  logic [SHARES*W-1:0] port_b,
    output logic [SHARES*W-1:0] port_c,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                fault
);
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

    state_t state, state_nxt;

    logic [SHARES-1:0][W-1:0] a_s, b_s, acc_q, sum, c_q;
    logic [SHARES-1:0]        flt;

    logic accept, hit, bad, good, sel_acc;
    logic c_ld, acc_ld, acc_clr;

    assign a_s    = port_a;
    assign b_s    = port_b;
    assign port_c = c_q;

    // While locked, out_valid is 0 so beats are absorbed every cycle.
    assign in_ready = fault || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign hit      = accept && !fault;
    assign bad      = hit && (|flt);    // only place shares are merged
    assign good     = hit && !(|flt);
    assign sel_acc  = in_op && (state == ACC);

    for (genvar i = 0; i < SHARES; i++) begin : g_share
        xor_nina_share #(.BITS(BITS), .K(K)) u_share (
            .a       (a_s[i]),
            .b       (b_s[i]),
            .acc     (acc_q[i]),
            .sel_acc (sel_acc),
            .sum     (sum[i]),
            .flt     (flt[i])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: only accepted accumulate beats move the FSM.
    always_comb begin
        state_nxt = state;
        if (bad) begin
            state_nxt = IDLE;
        end else if (good && in_op) begin
            case (state)
                IDLE:    if (!in_last) state_nxt = ACC;
                ACC:     if (in_last)  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath controls
    always_comb begin
        c_ld    = good && (!in_op || in_last);
        acc_ld  = good && in_op && !in_last;
        acc_clr = bad || (good && in_op && in_last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault     <= 1'b0;
            c_q       <= '0;
            out_valid <= 1'b0;
            acc_q     <= '0;
        end else begin
            if (bad) fault <= 1'b1;

            // A faulty beat kills any pending result at the same edge.
            if (fault || bad) begin
                c_q       <= '0;
                out_valid <= 1'b0;
            end else if (c_ld) begin
                c_q       <= sum;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (fault || acc_clr) acc_q <= '0;
            else if (acc_ld)      acc_q <= sum;
        end
    end
endmodule
